// File: rtl/branch_predict_unit_if.sv
// Pipeline-to-predictor bundle: IF-stage lookup, EX-stage resolution and training.
// Statistics outputs exist only when BP_STATS_EN is defined.
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [2:0]      ex_br_type;
    logic [XLEN-1:0] ex_reg1;
    logic [XLEN-1:0] ex_reg2;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;

    logic            br;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

`ifdef BP_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_br_type, ex_reg1, ex_reg2,
               ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, br, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_br_type, ex_reg1, ex_reg2,
               ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, br, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );
`else
    modport master (
        output if_pc, ex_valid, ex_pc, ex_br_type, ex_reg1, ex_reg2,
               ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, br, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_br_type, ex_reg1, ex_reg2,
               ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, br, mispredict, redirect_pc
    );
`endif
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit saturating counters plus EX-stage branch resolution.
// Optional feature macro: BP_STATS_EN adds branch / mispredict counters.
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = XLEN - $clog2(ENTRIES) - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Branch type encoding shared with Parameters.v of the pipeline.
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BLTU = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_ex_hit;
    logic             w_cond;

    // IF-stage lookup reads the table as it stands; a same-cycle update is not bypassed.
    assign w_if_idx = bus.if_pc[IDX_W+1:2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == bus.if_pc[XLEN-1:IDX_W+2]);

    assign bus.pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
    assign bus.pred_target = bus.pred_taken ? r_target[w_if_idx] : bus.if_pc + PC_STEP;

    assign w_ex_idx = bus.ex_pc[IDX_W+1:2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == bus.ex_pc[XLEN-1:IDX_W+2]);

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        w_cond = 1'b0;
        case (bus.ex_br_type)
            BR_BEQ:  w_cond = (bus.ex_reg1 == bus.ex_reg2);
            BR_BNE:  w_cond = (bus.ex_reg1 != bus.ex_reg2);
            BR_BLT:  w_cond = ($signed(bus.ex_reg1) <  $signed(bus.ex_reg2));
            BR_BGE:  w_cond = ($signed(bus.ex_reg1) >= $signed(bus.ex_reg2));
            BR_BLTU: w_cond = (bus.ex_reg1 <  bus.ex_reg2);
            BR_BGEU: w_cond = (bus.ex_reg1 >= bus.ex_reg2);
            default: w_cond = 1'b0;
        endcase
    end

    assign bus.br          = bus.ex_valid && w_cond;
    assign bus.mispredict  = bus.ex_valid &&
                             ((bus.br != bus.ex_pred_taken) ||
                              (bus.br && (bus.ex_target != bus.ex_pred_target)));
    assign bus.redirect_pc = bus.br ? bus.ex_target : bus.ex_pc + PC_STEP;

    // NOTE: the table is flop-based and cleared by the async reset because valid bits and
    // counters must be known immediately; a RAM-based table would only reset the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bus.ex_valid) begin
            // NOTE: non-blocking updates so every reader this cycle sees pre-edge state.
            if (w_ex_hit) begin
                if (bus.br) begin
                    if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                    r_target[w_ex_idx] <= bus.ex_target;
                end else if (r_ctr[w_ex_idx] != 2'b00) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end else if (bus.br) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= bus.ex_pc[XLEN-1:IDX_W+2];
                r_target[w_ex_idx] <= bus.ex_target;
                r_ctr[w_ex_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (bus.ex_valid)   r_stat_branches    <= r_stat_branches + 32'd1;
            if (bus.mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign bus.stat_branches    = r_stat_branches;
    assign bus.stat_mispredicts = r_stat_mispredicts;
`endif
endmodule
